// File: rtl/bin2seg_seq.sv
// Captures a 16-bit product, converts it to BCD (one double-dabble shift per cycle) and emits
// one active-low seven-segment digit per cycle. Optional feature macro: BLANK_LEADING_ZERO_EN.
module bin2seg_seq #(
   parameter int unsigned DIGITS = 5
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic [15:0] product,
   output logic [6:0]  seg,
   output logic [2:0]  seg_mux_sel,
   output logic        done,
   output logic        busy
);

   localparam int unsigned BcdW = 4 * DIGITS;

   typedef enum logic [1:0] {StIdle, StConv, StEmit} state_t;

   state_t            state_q, state_d;
   logic [BcdW-1:0]   bcd_q, bcd_d;
   logic [15:0]       bin_q, bin_d;
   logic [3:0]        cnt_q, cnt_d;
   logic [2:0]        idx_q, idx_d;
   logic [6:0]        seg_q, seg_d;
   logic [2:0]        sel_q, sel_d;
   logic              done_q, done_d;
   logic [BcdW-1:0]   bcd_adj;
   logic [BcdW+15:0]  shifted;
   logic [2:0]        idx_next;

   function automatic logic [6:0] encode(input logic [3:0] n);
      logic [6:0] p;
      case (n)
         4'd0:    p = 7'b0000001;
         4'd1:    p = 7'b1001111;
         4'd2:    p = 7'b0010010;
         4'd3:    p = 7'b0000110;
         4'd4:    p = 7'b1001100;
         4'd5:    p = 7'b0100100;
         4'd6:    p = 7'b0100000;
         4'd7:    p = 7'b0001111;
         4'd8:    p = 7'b0000000;
         4'd9:    p = 7'b0000100;
         default: p = 7'b1111110;
      endcase
      return p;
   endfunction

   function automatic logic [6:0] digit_pattern(input logic [BcdW-1:0] b, input logic [2:0] idx);
      logic [3:0] nib;
      logic [6:0] p;
`ifdef BLANK_LEADING_ZERO_EN
      logic       upper_zero;
      upper_zero = 1'b1;
      for (int i = 0; i < int'(DIGITS); i++) begin
         if (i >= int'(idx) && b[4*i +: 4] != 4'd0) upper_zero = 1'b0;
      end
`endif
      nib = 4'd0;
      for (int i = 0; i < int'(DIGITS); i++) begin
         if (idx == 3'(i)) nib = b[4*i +: 4];
      end
      p = encode(nib);
`ifdef BLANK_LEADING_ZERO_EN
      // Digit 0 always shows, so a zero product still reads "0".
      if (idx != 3'd0 && upper_zero) p = 7'b1111111;
`endif
      return p;
   endfunction

   always_comb begin
      for (int i = 0; i < int'(DIGITS); i++) begin
         bcd_adj[4*i +: 4] = (bcd_q[4*i +: 4] >= 4'd5) ? 4'(bcd_q[4*i +: 4] + 4'd3)
                                                       : bcd_q[4*i +: 4];
      end
      shifted = {bcd_adj, bin_q} << 1;
   end

   assign idx_next = idx_q + 3'd1;

   always_comb begin
      state_d = state_q;
      bcd_d   = bcd_q;
      bin_d   = bin_q;
      cnt_d   = cnt_q;
      idx_d   = idx_q;
      seg_d   = seg_q;
      sel_d   = 3'd0;
      done_d  = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (start) begin
               bcd_d   = '0;
               bin_d   = product;
               cnt_d   = 4'd0;
               state_d = StConv;
            end
         end
         StConv: begin
            bcd_d = shifted[BcdW+15:16];
            bin_d = shifted[15:0];
            cnt_d = cnt_q + 4'd1;
            // The 16th shift also presents digit 0, so the first digit lands on that edge.
            if (cnt_q == 4'd15) begin
               state_d = StEmit;
               idx_d   = 3'd0;
               seg_d   = digit_pattern(shifted[BcdW+15:16], 3'd0);
               done_d  = 1'b1;
            end
         end
         StEmit: begin
            if (idx_q == 3'(DIGITS - 1)) begin
               state_d = StIdle;
               idx_d   = 3'd0;
            end else begin
               idx_d  = idx_next;
               seg_d  = digit_pattern(bcd_q, idx_next);
               sel_d  = idx_next;
               done_d = 1'b1;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= StIdle;
         bcd_q   <= '0;
         bin_q   <= '0;
         cnt_q   <= 4'd0;
         idx_q   <= 3'd0;
         seg_q   <= 7'b0000001;
         sel_q   <= 3'd0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         bcd_q   <= bcd_d;
         bin_q   <= bin_d;
         cnt_q   <= cnt_d;
         idx_q   <= idx_d;
         seg_q   <= seg_d;
         sel_q   <= sel_d;
         done_q  <= done_d;
      end
   end

   assign seg         = seg_q;
   assign seg_mux_sel = sel_q;
   assign done        = done_q;
   assign busy        = (state_q != StIdle);

endmodule

// File: tb/tb_bin2seg_seq.sv
// Directed self-checking bench for bin2seg_seq (DIGITS = 5); expectations follow
// BLANK_LEADING_ZERO_EN when it is defined.
module tb_bin2seg_seq;

   localparam logic [6:0] S0 = 7'b0000001;
   localparam logic [6:0] S1 = 7'b1001111;
   localparam logic [6:0] S2 = 7'b0010010;
   localparam logic [6:0] S3 = 7'b0000110;
   localparam logic [6:0] S4 = 7'b1001100;
   localparam logic [6:0] S5 = 7'b0100100;
   localparam logic [6:0] S6 = 7'b0100000;
   localparam logic [6:0] S7 = 7'b0001111;
   localparam logic [6:0] S8 = 7'b0000000;
   localparam logic [6:0] S9 = 7'b0000100;
`ifdef BLANK_LEADING_ZERO_EN
   localparam logic [6:0] LZ = 7'b1111111;
`else
   localparam logic [6:0] LZ = 7'b0000001;
`endif

   typedef struct packed {
      logic [15:0]     product;
      logic [4:0][6:0] segs;
   } vec_t;

   logic        clk;
   logic        rst;
   logic        start;
   logic [15:0] product;
   logic [6:0]  seg;
   logic [2:0]  seg_mux_sel;
   logic        done;
   logic        busy;

   int n_checks;
   int n_pass;

   bin2seg_seq #(.DIGITS(5)) dut (
      .clk         (clk),
      .rst         (rst),
      .start       (start),
      .product     (product),
      .seg         (seg),
      .seg_mux_sel (seg_mux_sel),
      .done        (done),
      .busy        (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
      n_checks++;
      if (act !== exp) $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      else n_pass++;
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, " seg"}, 16'(seg), 16'(S0));
      check({tag, " sel"}, 16'(seg_mux_sel), 16'd0);
      check({tag, " done"}, 16'(done), 16'd0);
      check({tag, " busy"}, 16'(busy), 16'd0);
   endtask

   function automatic vec_t mk(input logic [15:0] p, input logic [6:0] d0, input logic [6:0] d1,
                               input logic [6:0] d2, input logic [6:0] d3, input logic [6:0] d4);
      vec_t v;
      v.product = p;
      v.segs    = {d4, d3, d2, d1, d0};
      return v;
   endfunction

   // Starts a conversion from IDLE and checks every cycle up to busy falling.
   // glitch_at > 0 pulses start with another product just before edge E<glitch_at>.
   task automatic run_txn(input vec_t v, input int glitch_at, input string tag);
      product = v.product;
      start   = 1'b1;
      step();
      start   = 1'b0;
      check({tag, " busy@E0"}, 16'(busy), 16'd1);
      for (int i = 1; i <= 15; i++) begin
         if (i == glitch_at) begin
            product = ~v.product;
            start   = 1'b1;
         end
         step();
         start = 1'b0;
      end
      check({tag, " done@E15"}, 16'(done), 16'd0);
      check({tag, " busy@E15"}, 16'(busy), 16'd1);
      for (int k = 0; k < 5; k++) begin
         step();
         check($sformatf("%s done d%0d", tag, k), 16'(done), 16'd1);
         check($sformatf("%s sel d%0d", tag, k), 16'(seg_mux_sel), 16'(k));
         check($sformatf("%s seg d%0d", tag, k), 16'(seg), 16'(v.segs[k]));
      end
      step();
      check({tag, " done end"}, 16'(done), 16'd0);
      check({tag, " busy end"}, 16'(busy), 16'd0);
      check({tag, " sel end"}, 16'(seg_mux_sel), 16'd0);
   endtask

   initial begin
      vec_t vecs[6];
      n_checks = 0;
      n_pass   = 0;
      rst      = 1'b0;
      start    = 1'b0;
      product  = 16'd0;

      vecs[0] = mk(16'd0,     S0, LZ, LZ, LZ, LZ);
      vecs[1] = mk(16'd65025, S5, S2, S0, S5, S6);
      vecs[2] = mk(16'd1234,  S4, S3, S2, S1, LZ);
      vecs[3] = mk(16'd7080,  S0, S8, S0, S7, LZ);
      vecs[4] = mk(16'd65535, S5, S3, S5, S5, S6);
      vecs[5] = mk(16'd99,    S9, S9, LZ, LZ, LZ);

      step();
      check_reset_outputs("reset");
      #2 rst = 1'b1;
      step();
      check_reset_outputs("post-reset idle");

      for (int i = 0; i < 6; i++) run_txn(vecs[i], 0, $sformatf("vec%0d", i));

      // start during CONV is ignored; digits follow the captured product
      run_txn(vecs[1], 5, "ignored start");

      // Back-to-back: start in the first IDLE cycle after busy falls
      run_txn(vecs[2], 0, "b2b first");
      run_txn(vecs[5], 0, "b2b second");

      // Reset mid-CONV: seg currently holds the last digit of 99 (LZ) so use 65025 first
      run_txn(vecs[1], 0, "pre-reset");
      product = 16'd12345;
      start   = 1'b1;
      step();
      start   = 1'b0;
      repeat (9) step();
      #2 rst = 1'b0;
      #1;
      check_reset_outputs("reset mid-conv");
      step();
      #2 rst = 1'b1;
      for (int i = 0; i < 20; i++) begin
         step();
         check($sformatf("no partial done c%0d", i), 16'(done), 16'd0);
         check($sformatf("no partial busy c%0d", i), 16'(busy), 16'd0);
      end
      run_txn(vecs[4], 0, "after reset 65535");

      // Reset mid-EMIT
      product = 16'd65025;
      start   = 1'b1;
      step();
      start   = 1'b0;
      repeat (17) step();
      check("mid-emit done", 16'(done), 16'd1);
      #2 rst = 1'b0;
      #1;
      check_reset_outputs("reset mid-emit");
      #2 rst = 1'b1;
      repeat (3) step();
      check("after emit reset done", 16'(done), 16'd0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
